// File: rtl/upsample_nearest.sv
// Nearest-neighbour upsampler: repeats each element ScaleWidth times and each row
// ScaleHeight times, replaying rows from an inferred line buffer.
module upsample_nearest #(
  parameter int InHeight    = 300,
  parameter int InWidth     = 400,
  parameter int ScaleHeight = 2,
  parameter int ScaleWidth  = 2,
  parameter int DataWidth   = 24
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 slave_valid_i,
  output logic                 slave_ready_o,
  input  logic [DataWidth-1:0] slave_data_i,
  output logic                 master_valid_o,
  input  logic                 master_ready_i,
  output logic [DataWidth-1:0] master_data_o
);

  localparam int CW = (InWidth > 1) ? $clog2(InWidth) : 1;
  localparam int RW = (InHeight > 1) ? $clog2(InHeight) : 1;
  localparam int HW = (ScaleWidth > 1) ? $clog2(ScaleWidth) : 1;
  localparam int VW = (ScaleHeight > 1) ? $clog2(ScaleHeight) : 1;

  localparam logic [CW-1:0] COL_LAST  = CW'(InWidth - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(InHeight - 1);
  localparam logic [HW-1:0] HREP_LAST = HW'(ScaleWidth - 1);
  localparam logic [VW-1:0] VREP_LAST = VW'(ScaleHeight - 1);

  typedef enum logic {LIVE, REPLAY} state_t;

  state_t               state_reg, state_next;
  logic [CW-1:0]        col_reg, col_next;
  logic [RW-1:0]        row_reg, row_next;
  logic [HW-1:0]        hrep_reg, hrep_next;
  logic [VW-1:0]        vrep_reg, vrep_next;
  logic                 out_valid_reg, out_valid_next;
  logic [DataWidth-1:0] out_data_reg, out_data_next;
  logic                 last_col_reg, last_col_next;
  logic [DataWidth-1:0] rd_data_reg;
  logic [DataWidth-1:0] linebuf [InWidth];

  logic hrep_last, xfer, slot_free, final_pass, hold_for_switch;
  logic accept, replay_load, load, pass_end;

  always_comb begin
    hrep_last  = (hrep_reg == HREP_LAST);
    xfer       = out_valid_reg && master_ready_i;
    slot_free  = !out_valid_reg || (xfer && hrep_last);
    pass_end   = xfer && hrep_last && last_col_reg;
    // When the element in flight closes the last copy of a row, the next element
    // comes from the other source, so no load may overlap that final transfer.
    final_pass = (state_reg == LIVE) ? (ScaleHeight > 1) : (vrep_reg == VREP_LAST);
    hold_for_switch = out_valid_reg && last_col_reg && final_pass;

    slave_ready_o = !reset_i && (state_reg == LIVE) && slot_free && !hold_for_switch;
    accept        = slave_valid_i && slave_ready_o;
    replay_load   = (state_reg == REPLAY) && slot_free && !hold_for_switch;
    load          = accept || replay_load;
  end

  always_comb begin
    state_next     = state_reg;
    col_next       = col_reg;
    row_next       = row_reg;
    hrep_next      = hrep_reg;
    vrep_next      = vrep_reg;
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    last_col_next  = last_col_reg;

    if (xfer && !hrep_last) begin
      hrep_next = hrep_reg + HW'(1);
    end
    if (xfer && hrep_last) begin
      out_valid_next = 1'b0;
    end
    if (load) begin
      out_valid_next = 1'b1;
      out_data_next  = accept ? slave_data_i : rd_data_reg;
      hrep_next      = '0;
      last_col_next  = (col_reg == COL_LAST);
      col_next       = (col_reg == COL_LAST) ? '0 : col_reg + CW'(1);
    end

    if (pass_end) begin
      if (state_reg == LIVE) begin
        if (ScaleHeight > 1) begin
          state_next = REPLAY;
          vrep_next  = VW'(1);
        end else begin
          row_next = (row_reg == ROW_LAST) ? '0 : row_reg + RW'(1);
        end
      end else if (vrep_reg == VREP_LAST) begin
        state_next = LIVE;
        vrep_next  = '0;
        row_next   = (row_reg == ROW_LAST) ? '0 : row_reg + RW'(1);
      end else begin
        vrep_next = vrep_reg + VW'(1);
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_reg     <= LIVE;
      col_reg       <= '0;
      row_reg       <= '0;
      hrep_reg      <= '0;
      vrep_reg      <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      last_col_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      col_reg       <= col_next;
      row_reg       <= row_next;
      hrep_reg      <= hrep_next;
      vrep_reg      <= vrep_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      last_col_reg  <= last_col_next;
    end
  end

  // Reading at col_next keeps rd_data_reg equal to linebuf[col_reg], so replay
  // loads run back-to-back without a read bubble.
  always_ff @(posedge clock_i) begin
    if (accept) begin
      linebuf[col_reg] <= slave_data_i;
    end
    rd_data_reg <= linebuf[col_next];
  end

  assign master_valid_o = out_valid_reg;
  assign master_data_o  = out_data_reg;

endmodule
